funct_generator_adder_pipe: RTL
===============================

Name: funct_generator_adder_pipe

Overview:
Parametrised, pipelined N-input unsigned adder for the function generator datapath.
- Replaces the fixed 3-input combinational adder: registered binary adder tree with one register per tree level.
- valid/ready handshake on both sides, with per-stage bubble collapse.
- Synchronous clear (clrh) and stall enable (enh).
- Optional saturation when the output is narrower than the full sum width.
- Sits between the waveform channel sources and the output FIFO write port.

Parameters:
- NUM_INPUTS, 4: number of addends; legal range 2..16; non-power-of-two counts are zero-padded to the next power of two.
- DATA_WIDTH_IN, 5: width of each unsigned addend.
- DATA_WIDTH_OUT, 7: output width; full sum width FULL_W = DATA_WIDTH_IN + $clog2(NUM_INPUTS).
- SAT_EN, 1: applies when DATA_WIDTH_OUT < FULL_W; 1 = saturate to all-ones, 0 = truncate (keep LSBs).

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- clrh, input, 1: synchronous flush, active high.
- enh, input, 1: pipeline enable; low = freeze.
- data_i, input, NUM_INPUTS x DATA_WIDTH_IN: packed array of addends.
- valid_i, input, 1: data_i valid.
- ready_o, output, 1: block accepts data_i this cycle.
- data_o, output, DATA_WIDTH_OUT: sum.
- valid_o, output, 1: data_o valid.
- ready_i, input, 1: downstream accepts data_o.
- ovf_o, output, 1: sum exceeded DATA_WIDTH_OUT; qualified by valid_o.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: while rst_n = 0, all stage valid bits, data registers, data_o, valid_o and ovf_o are 0; ready_o is 1 after reset release when enh = 1.
- Tree depth: LEVELS = $clog2(NUM_INPUTS). Stage k (1..LEVELS) registers the pairwise sums of stage k-1; stage 0 is data_i, unregistered.
- Stage widths: stage k data width is DATA_WIDTH_IN + k. There is no intermediate truncation.
- Final stage: the last stage also registers the width reduction and ovf_o.
- Latency: a word accepted on edge t (valid_i & ready_o) appears with valid_o = 1 after edge t+LEVELS when no stall occurs. With the defaults this is 2 cycles.
- Throughput: 1 word/cycle sustained while ready_i = 1.
- Stage advance rule: stage k loads when enh = 1 and (stage k empty, or stage k+1 loads, or k = LEVELS and ready_i = 1). Bubbles collapse.
- ready_o equals the stage 1 load condition. It is combinational from ready_i through the stage chain; this is accepted.
- Held data: data_o and ovf_o stay stable while valid_o = 1 and ready_i = 0.
- Width reduction, DATA_WIDTH_OUT >= FULL_W: zero-extend; ovf_o = 0.
- Width reduction, DATA_WIDTH_OUT < FULL_W: ovf_o = 1 when any discarded MSB is 1. With SAT_EN = 1, data_o = all-ones; with SAT_EN = 0, data_o = the LSBs.
- enh = 0: no stage loads; ready_o = 0; valid_o and data_o hold. Downstream may still see valid_o = 1; a handshake completed while enh = 0 does not pop the data. The same word is re-presented until a cycle with enh = 1 and ready_i = 1.
- clrh = 1, which has priority over enh and the handshake: on the next edge all valid bits clear and data registers go to 0. In-flight words are discarded; ready_o = 0 during clrh. A word offered in the same cycle as clrh is not accepted.
- Reset mid-operation: in-flight words are lost immediately; there is no partial output.
- Arithmetic: all addends unsigned; pad inputs are tied to 0.

Decomposition:
- Package funct_generator_pkg holds:
  - function adder_levels(n) returning $clog2(n);
  - function full_width(win, n);
  - localparam MAX_INPUTS = 16.
- Sub-module funct_generator_adder_stage implements one registered tree level. Parameters: LANES_IN, W_IN. It owns its data, valid, load and ready logic. The top instantiates LEVELS of them via generate and adds the output width-reduction logic to the last stage.

Test Plan:
- Basic sum (defaults): data_i = {1,2,3,4}, valid_i = 1 for one cycle, ready_i = 1 -> valid_o = 1 exactly 2 cycles later with data_o = 10, ovf_o = 0.
- Max value (defaults): data_i = {31,31,31,31} -> data_o = 124, ovf_o = 0. With DATA_WIDTH_OUT = 6 and SAT_EN = 1 -> data_o = 63, ovf_o = 1. With SAT_EN = 0 -> data_o = 60, ovf_o = 1.
- Streaming and backpressure: 8 back-to-back words of value k,k,k,k for k = 0..7, with ready_i low on cycles 3-5 -> outputs 0,4,...,28 in order, none lost or duplicated, data_o stable while stalled. Once the pipe is full, ready_o = 0 until ready_i returns high.
- enh freeze: drop enh for 3 cycles with 2 words in flight -> no valid_o transition and no acceptance during the freeze; both words emerge after enh = 1.
- clrh flush: clrh for 1 cycle with 2 words in flight -> valid_o = 0 on the next cycle and neither word appears. A word offered during clrh is not accepted; a word offered next cycle produces its correct sum.
- Async reset: assert rst_n = 0 mid-edge while streaming -> valid_o, data_o and ovf_o go to 0 immediately. After release, a new word {5,0,0,0} gives data_o = 5.
- Non-power-of-two: NUM_INPUTS = 3, data_i = {7,8,9} -> data_o = 24 after 2 cycles.

Source files
------------

// File: rtl/funct_generator_pkg.sv
// Shared sizing helpers for the function generator adder tree.
// Widths are derived from addend count so every stage stays lossless.
package funct_generator_pkg;

   localparam int MAX_INPUTS = 16;

   function automatic int adder_levels(input int n);
      return $clog2(n);
   endfunction

   function automatic int full_width(input int win, input int n);
      return win + $clog2(n);
   endfunction

endpackage

// File: rtl/funct_generator_adder_stage.sv
// One registered level of the adder tree: pairwise sums of its input lanes.
// Loads when empty or when the level below drains; bubbles collapse.
module funct_generator_adder_stage #(
   parameter int LANES_IN = 2,
   parameter int W_IN     = 5
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                clrh,
   input  logic                                enh,
   input  logic                                valid_i,
   input  logic [LANES_IN*W_IN-1:0]            data_i,
   output logic                                ready_o,
   output logic                                valid_o,
   output logic [(LANES_IN/2)*(W_IN+1)-1:0]    data_o,
   input  logic                                ready_i
);

   localparam int LO = LANES_IN / 2;
   localparam int WO = W_IN + 1;

   logic [LO*WO-1:0] sum;

   always_comb begin
      sum = '0;
      for (int i = 0; i < LO; i++) begin
         sum[i*WO +: WO] = WO'(data_i[2*i*W_IN +: W_IN])
                         + WO'(data_i[(2*i+1)*W_IN +: W_IN]);
      end
   end

   assign ready_o = enh & ~clrh & (~valid_o | ready_i);

   // Data only moves with a valid word so a held output never changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_o <= 1'b0;
         data_o  <= '0;
      end else if (clrh) begin
         valid_o <= 1'b0;
         data_o  <= '0;
      end else if (ready_o) begin
         valid_o <= valid_i;
         if (valid_i) begin
            data_o <= sum;
         end
      end
   end

endmodule

// File: rtl/funct_generator_adder_pipe.sv
// Pipelined N-input unsigned adder tree with valid/ready flow control.
// Output is width-reduced with optional saturation and overflow flag.
module funct_generator_adder_pipe
   import funct_generator_pkg::*;
#(
   parameter int NUM_INPUTS     = 4,
   parameter int DATA_WIDTH_IN  = 5,
   parameter int DATA_WIDTH_OUT = 7,
   parameter int SAT_EN         = 1
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      clrh,
   input  logic                                      enh,
   input  logic [NUM_INPUTS-1:0][DATA_WIDTH_IN-1:0]  data_i,
   input  logic                                      valid_i,
   output logic                                      ready_o,
   output logic [DATA_WIDTH_OUT-1:0]                 data_o,
   output logic                                      valid_o,
   input  logic                                      ready_i,
   output logic                                      ovf_o
);

   localparam int LEVELS = adder_levels(NUM_INPUTS);
   localparam int FULL_W = full_width(DATA_WIDTH_IN, NUM_INPUTS);
   localparam int NP     = 1 << LEVELS;

   logic [NP*DATA_WIDTH_IN-1:0] padded;
   logic [LEVELS:0]             vld;
   logic [LEVELS+1:1]           rdy;
   logic [FULL_W-1:0]           fsum;

   always_comb begin
      padded = '0;
      padded[NUM_INPUTS*DATA_WIDTH_IN-1:0] = data_i;
   end

   assign vld[0]        = valid_i;
   assign rdy[LEVELS+1] = ready_i;
   assign ready_o       = rdy[1];
   assign valid_o       = vld[LEVELS];

   for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int LIN = NP >> (k - 1);
      localparam int WIN = DATA_WIDTH_IN + k - 1;

      logic [LIN*WIN-1:0]         din;
      logic [(LIN/2)*(WIN+1)-1:0] dout;

      if (k == 1) begin : g_src
         assign din = padded;
      end else begin : g_src
         assign din = g_lvl[k-1].dout;
      end

      funct_generator_adder_stage #(
         .LANES_IN (LIN),
         .W_IN     (WIN)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .clrh    (clrh),
         .enh     (enh),
         .valid_i (vld[k-1]),
         .data_i  (din),
         .ready_o (rdy[k]),
         .valid_o (vld[k]),
         .data_o  (dout),
         .ready_i (rdy[k+1])
      );
   end

   assign fsum = g_lvl[LEVELS].dout;

   // Reduction is pure logic on the last register, so it holds with it.
   if (DATA_WIDTH_OUT >= FULL_W) begin : g_wide
      assign data_o = DATA_WIDTH_OUT'(fsum);
      assign ovf_o  = 1'b0;
   end else begin : g_narrow
      logic ov;
      assign ov     = |fsum[FULL_W-1:DATA_WIDTH_OUT];
      assign ovf_o  = ov;
      assign data_o = ((SAT_EN != 0) && ov) ? {DATA_WIDTH_OUT{1'b1}}
                                            : fsum[DATA_WIDTH_OUT-1:0];
   end

endmodule
